// File: rtl/rsa2048_axi_pkg.sv
// Shared constants, types and helpers for the AXI4 RSA-2048 slave.
package rsa2048_axi_pkg;

  localparam int NWORDS = 64;
  localparam int KEY_W  = NWORDS * 32;

  localparam logic [11:0] OFS_CTRL   = 12'h000;
  localparam logic [11:0] OFS_STATUS = 12'h004;
  localparam logic [11:0] OFS_M      = 12'h100;
  localparam logic [11:0] OFS_E      = 12'h200;
  localparam logic [11:0] OFS_N      = 12'h300;
  localparam logic [11:0] OFS_RES    = 12'h400;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
  typedef enum logic [1:0] {E_IDLE, E_MUL, E_NEXT}  e_state_t;
  typedef enum logic [1:0] {OP_RED, OP_RMUL, OP_SQR} e_op_t;

  typedef logic [NWORDS-1:0][31:0] key_t;

  // Latched context of the single outstanding burst on one direction.
  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [7:0]  cnt;
  } burst_t;

  // Zero-width user signals still need a 1-bit port.
  function automatic int user_w(input int w);
    return (w > 0) ? w : 1;
  endfunction

  // FIXED holds the address; INCR and WRAP both advance one word.
  function automatic logic [11:0] burst_next(input burst_t b);
    return (b.burst == BURST_FIXED) ? b.addr : b.addr + 12'd4;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/rsa2048_modexp.sv
// Right-to-left binary modular exponentiation; each modular multiply is a
// bit-serial add/double over the multiplier that stops once it runs out of bits.
module rsa2048_modexp
  import rsa2048_axi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] m,
  input  logic [KEY_W-1:0] e,
  input  logic [KEY_W-1:0] n,
  output logic             done,
  output logic [KEY_W-1:0] result
);

  e_state_t         state, state_nx;
  e_op_t            op;
  logic [KEY_W-1:0] n_q, exp_q, res_q, base_q, acc, ma, mb;

  // (a + b) mod md for a, b < md; one conditional subtract suffices.
  function automatic logic [KEY_W-1:0] add_mod(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b,
                                               input logic [KEY_W-1:0] md);
    logic [KEY_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, md}) s = s - {1'b0, md};
    return s[KEY_W-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= E_IDLE;
    else        state <= state_nx;

  // Next state: a multiply ends when the multiplier is exhausted.
  always_comb begin
    state_nx = state;
    case (state)
      E_IDLE:  if (start) state_nx = E_MUL;
      E_MUL:   if (mb == '0) state_nx = E_NEXT;
      E_NEXT:  state_nx = (exp_q == '0) ? E_IDLE : E_MUL;
      default: state_nx = E_IDLE;
    endcase
  end

  // Outputs: done pulses on the single cycle with nothing left to do.
  always_comb begin
    done   = (state == E_NEXT) && (exp_q == '0);
    result = res_q;
  end

  // Datapath: operands, accumulator and exponent scan.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op <= OP_RED;
      {n_q, exp_q, res_q, base_q, acc, ma, mb} <= '0;
    end else begin
      case (state)
        E_IDLE: if (start) begin
          // First multiply is 1*m, which reduces m below n.
          n_q <= n; exp_q <= e; res_q <= KEY_W'(1);
          acc <= '0; ma <= KEY_W'(1); mb <= m; op <= OP_RED;
        end
        E_MUL: if (mb != '0) begin
          if (mb[0]) acc <= add_mod(acc, ma, n_q);
          ma <= add_mod(ma, ma, n_q);
          mb <= mb >> 1;
        end else begin
          case (op)
            OP_RED:  base_q <= acc;
            OP_RMUL: begin res_q <= acc; exp_q[0] <= 1'b0; end
            default: begin base_q <= acc; exp_q <= exp_q >> 1; end
          endcase
        end
        E_NEXT: if (exp_q != '0) begin
          acc <= '0;
          mb  <= base_q;
          if (exp_q[0]) begin op <= OP_RMUL; ma <= res_q;  end
          else          begin op <= OP_SQR;  ma <= base_q; end
        end
        default: ;
      endcase
    end

endmodule

// File: rtl/axi4_rsa2048_slave.sv
// AXI4 slave: independent write/read burst FSMs, M/E/N/RESULT register file
// and the START/BUSY/DONE handshake with the modexp engine.
module axi4_rsa2048_slave
  import rsa2048_axi_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH     = 1,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_S_AXI_ADDR_WIDTH   = 32,
  parameter int C_S_AXI_AWUSER_WIDTH = 0,
  parameter int C_S_AXI_ARUSER_WIDTH = 0,
  parameter int C_S_AXI_WUSER_WIDTH  = 0,
  parameter int C_S_AXI_RUSER_WIDTH  = 0,
  parameter int C_S_AXI_BUSER_WIDTH  = 0
) (
  input  logic                                    S_AXI_ACLK,
  input  logic                                    S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]             S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic [7:0]                              S_AXI_AWLEN,
  input  logic [2:0]                              S_AXI_AWSIZE,
  input  logic [1:0]                              S_AXI_AWBURST,
  input  logic                                    S_AXI_AWLOCK,
  input  logic [3:0]                              S_AXI_AWCACHE,
  input  logic [2:0]                              S_AXI_AWPROT,
  input  logic [3:0]                              S_AXI_AWQOS,
  input  logic [3:0]                              S_AXI_AWREGION,
  input  logic [user_w(C_S_AXI_AWUSER_WIDTH)-1:0] S_AXI_AWUSER,
  input  logic                                    S_AXI_AWVALID,
  output logic                                    S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                                    S_AXI_WLAST,
  input  logic [user_w(C_S_AXI_WUSER_WIDTH)-1:0]  S_AXI_WUSER,
  input  logic                                    S_AXI_WVALID,
  output logic                                    S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]             S_AXI_BID,
  output logic [1:0]                              S_AXI_BRESP,
  output logic [user_w(C_S_AXI_BUSER_WIDTH)-1:0]  S_AXI_BUSER,
  output logic                                    S_AXI_BVALID,
  input  logic                                    S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]             S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic [7:0]                              S_AXI_ARLEN,
  input  logic [2:0]                              S_AXI_ARSIZE,
  input  logic [1:0]                              S_AXI_ARBURST,
  input  logic                                    S_AXI_ARLOCK,
  input  logic [3:0]                              S_AXI_ARCACHE,
  input  logic [2:0]                              S_AXI_ARPROT,
  input  logic [3:0]                              S_AXI_ARQOS,
  input  logic [3:0]                              S_AXI_ARREGION,
  input  logic [user_w(C_S_AXI_ARUSER_WIDTH)-1:0] S_AXI_ARUSER,
  input  logic                                    S_AXI_ARVALID,
  output logic                                    S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]             S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                              S_AXI_RRESP,
  output logic                                    S_AXI_RLAST,
  output logic [user_w(C_S_AXI_RUSER_WIDTH)-1:0]  S_AXI_RUSER,
  output logic                                    S_AXI_RVALID,
  input  logic                                    S_AXI_RREADY
);

  w_state_t                    w_state, w_state_nx;
  r_state_t                    r_state, r_state_nx;
  burst_t                      wb, rb;
  logic [C_S_AXI_ID_WIDTH-1:0] w_id, r_id;
  logic                        alive, aw_hs, w_hs, w_last, ar_hs, r_hs;
  key_t                        m_r, e_r, n_r, res_r;
  logic                        busy, done, eng_start, eng_done;
  logic [KEY_W-1:0]            eng_res;
  logic [11:0]                 rd_addr;
  logic [31:0]                 rd_data, rdata_q;
  logic [5:0]                  w_idx;
  logic                        unused_ok;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign w_last = S_AXI_WLAST || (wb.cnt == wb.len);
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs   = S_AXI_RVALID && S_AXI_RREADY;
  assign w_idx  = wb.addr[7:2];

  assign unused_ok = ^{S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                       S_AXI_AWQOS, S_AXI_AWREGION, S_AXI_AWUSER, S_AXI_WUSER,
                       S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                       S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_ARUSER};

  // Holds ready low until the first clock after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) alive <= 1'b0;
    else                alive <= 1'b1;

  // FSM state registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nx;
      r_state <= r_state_nx;
    end

  // Next-state logic for both directions.
  always_comb begin
    w_state_nx = w_state;
    r_state_nx = r_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
      W_DATA:  if (w_hs && w_last) w_state_nx = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nx = R_DATA;
      R_DATA:  if (r_hs && S_AXI_RLAST) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Channel outputs decoded from state.
  always_comb begin
    S_AXI_AWREADY = alive && (w_state == W_IDLE);
    S_AXI_WREADY  = (w_state == W_DATA);
    S_AXI_BVALID  = (w_state == W_RESP);
    S_AXI_BID     = w_id;
    S_AXI_BRESP   = RESP_OKAY;
    S_AXI_BUSER   = '0;
    S_AXI_ARREADY = alive && (r_state == R_IDLE);
    S_AXI_RVALID  = (r_state == R_DATA);
    S_AXI_RLAST   = S_AXI_RVALID && (rb.cnt == rb.len);
    S_AXI_RID     = r_id;
    S_AXI_RDATA   = rdata_q;
    S_AXI_RRESP   = RESP_OKAY;
    S_AXI_RUSER   = '0;
  end

  // Burst context capture and per-beat address advance.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      wb <= '0; rb <= '0; w_id <= '0; r_id <= '0; rdata_q <= '0;
    end else begin
      if (aw_hs) begin
        wb   <= '{addr: S_AXI_AWADDR[11:0], len: S_AXI_AWLEN, burst: S_AXI_AWBURST, cnt: 8'd0};
        w_id <= S_AXI_AWID;
      end else if (w_hs) begin
        wb.addr <= burst_next(wb);
        wb.cnt  <= wb.cnt + 8'd1;
      end
      if (ar_hs) begin
        rb      <= '{addr: S_AXI_ARADDR[11:0], len: S_AXI_ARLEN, burst: S_AXI_ARBURST, cnt: 8'd0};
        r_id    <= S_AXI_ARID;
        rdata_q <= rd_data;
      end else if (r_hs && !S_AXI_RLAST) begin
        rb.addr <= rd_addr;
        rb.cnt  <= rb.cnt + 8'd1;
        rdata_q <= rd_data;
      end
    end

  // Read decode of the address the next beat will present.
  always_comb begin
    rd_addr = (r_state == R_IDLE) ? S_AXI_ARADDR[11:0] : burst_next(rb);
    rd_data = '0;
    case (rd_addr[11:8])
      OFS_CTRL[11:8]: if (rd_addr[7:2] == OFS_STATUS[7:2]) rd_data = {30'd0, done, busy};
      OFS_M[11:8]:    rd_data = m_r[rd_addr[7:2]];
      OFS_E[11:8]:    rd_data = e_r[rd_addr[7:2]];
      OFS_N[11:8]:    rd_data = n_r[rd_addr[7:2]];
      OFS_RES[11:8]:  rd_data = res_r[rd_addr[7:2]];
      default:        rd_data = '0;
    endcase
  end

  // Register file writes and engine handshake; engine completion wins over START.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      m_r <= '0; e_r <= '0; n_r <= '0; res_r <= '0;
      busy <= 1'b0; done <= 1'b0; eng_start <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      if (eng_done) begin
        res_r <= eng_res;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else if (w_hs && !busy && wb.addr[11:2] == OFS_CTRL[11:2] &&
                   S_AXI_WSTRB[0] && S_AXI_WDATA[0]) begin
        eng_start <= 1'b1;
        busy      <= 1'b1;
        done      <= 1'b0;
      end
      if (w_hs && !busy) begin
        case (wb.addr[11:8])
          OFS_M[11:8]: m_r[w_idx] <= byte_merge(m_r[w_idx], S_AXI_WDATA, S_AXI_WSTRB);
          OFS_E[11:8]: e_r[w_idx] <= byte_merge(e_r[w_idx], S_AXI_WDATA, S_AXI_WSTRB);
          OFS_N[11:8]: n_r[w_idx] <= byte_merge(n_r[w_idx], S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
    end

  rsa2048_modexp u_modexp (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .start  (eng_start),
    .m      (m_r),
    .e      (e_r),
    .n      (n_r),
    .done   (eng_done),
    .result (eng_res)
  );

endmodule

// File: tb/tb_axi4_rsa2048_slave.sv
// Randomized bench for axi4_rsa2048_slave against a word-array register model.
`timescale 1ns/1ps
module tb_axi4_rsa2048_slave;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [0:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [0:0]  buser, ruser;

  always #5 clk = ~clk;

  axi4_rsa2048_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(3'd2),
    .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
    .S_AXI_AWQOS(4'd0), .S_AXI_AWREGION(4'd0), .S_AXI_AWUSER(1'b0), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WUSER(1'b0),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(3'd2),
    .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
    .S_AXI_ARQOS(4'd0), .S_AXI_ARREGION(4'd0), .S_AXI_ARUSER(1'b0), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One 32-bit word per 4-byte offset of the 4 KiB window.
  logic [31:0] mdl [0:1023];
  bit          mbusy, mdone;
  logic [31:0] wbuf [0:255];
  logic [31:0] rbuf [0:255];
  logic [0:0]  cur_id;

  function automatic void mdl_clear();
    foreach (mdl[i]) mdl[i] = '0;
    mbusy = 0; mdone = 0;
  endfunction

  function automatic logic [31:0] mrd(input logic [11:0] a);
    if (a[11:8] == 4'h0) return (a[7:2] == 6'd1) ? {30'd0, mdone, mbusy} : 32'd0;
    if (a[11:8] >= 4'h1 && a[11:8] <= 4'h4) return mdl[a[11:2]];
    return 32'd0;
  endfunction

  function automatic void mwr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[11:2] == 10'd0 && s[0] && d[0] && !mbusy) begin mbusy = 1; mdone = 0; end
    if (a[11:8] >= 4'h1 && a[11:8] <= 4'h3 && !mbusy)
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Left-to-right square-and-multiply on values below 2^32.
  function automatic longint unsigned ref_modexp(input longint unsigned m, input longint unsigned e,
                                                 input longint unsigned n);
    longint unsigned r, b;
    r = 1 % n; b = m % n;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * b) % n;
    end
    return r;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic wr_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] strb, input int bstall);
    int t; logic [11:0] a;
    cur_id = 1'($urandom_range(0, 1));
    @(negedge clk);
    awid = cur_id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1;
    t = 0; while (!awready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("aw_timeout", 1, 0);
    @(negedge clk); awvalid = 0;
    a = addr[11:0];
    for (int i = 0; i <= len; i++) begin
      wdata = wbuf[i]; wstrb = strb; wlast = (i == len); wvalid = 1;
      t = 0; while (!wready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("w_timeout", 1, 0);
      @(negedge clk);
      mwr(a, wbuf[i], strb);
      if (burst != 2'd0) a = a + 12'd4;
    end
    wvalid = 0; wlast = 0;
    for (int k = 0; k < bstall; k++) begin check("bvalid_hold", bvalid, 1); @(negedge clk); end
    bready = 1;
    t = 0; while (!bvalid && t < 200) begin @(negedge clk); t++; end
    check("bvalid", bvalid, 1);
    check("bid", bid, cur_id);
    check("bresp", bresp, 0);
    @(negedge clk); bready = 0;
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int rstall);
    int t; logic [31:0] d0;
    cur_id = 1'($urandom_range(0, 1));
    @(negedge clk);
    arid = cur_id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1;
    t = 0; while (!arready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("ar_timeout", 1, 0);
    @(negedge clk); arvalid = 0;
    for (int i = 0; i <= len; i++) begin
      if (i == 0 && rstall > 0) begin
        d0 = rdata;
        for (int k = 0; k < rstall; k++) begin
          @(negedge clk);
          check("rvalid_hold", rvalid, 1);
          check("rdata_hold", rdata, d0);
        end
      end
      rready = 1;
      t = 0; while (!rvalid && t < 200) begin @(negedge clk); t++; end
      check("rvalid", rvalid, 1);
      rbuf[i] = rdata;
      check($sformatf("rlast[%0d]", i), rlast, (i == len));
      check("rresp", rresp, 0);
      check("rid", rid, cur_id);
      @(negedge clk);
    end
    rready = 0;
  endtask

  // Read back and compare each beat to the model.
  task automatic rd_cmp(input string tag, input logic [31:0] addr, input int len,
                        input logic [1:0] burst, input int rstall);
    logic [11:0] a;
    rd_burst(addr, len, burst, rstall);
    a = addr[11:0];
    for (int i = 0; i <= len; i++) begin
      check($sformatf("%s[%0d]", tag, i), rbuf[i], mrd(a));
      if (burst != 2'd0) a = a + 12'd4;
    end
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [31:0] d);
    wbuf[0] = d;
    wr_burst(addr, 0, 2'd1, 4'hF, 0);
  endtask

  // Poll STATUS until DONE, then fold the expected result into the model.
  task automatic wait_done(input longint unsigned r);
    int polls = 0;
    do begin rd_burst(32'h7800_0004, 0, 2'd1, 0); polls++; end
    while (!rbuf[0][1] && polls < 1500);
    check("status_done", rbuf[0], 32'd2);
    mbusy = 0; mdone = 1;
    for (int i = 0; i < 64; i++) mdl[(12'h400 >> 2) + i] = (i == 0) ? r[31:0] : 32'd0;
  endtask

  task automatic reset_dut(input int cyc);
    @(negedge clk);
    rst_n = 0;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    mdl_clear();
    #1;
    check("rst_valids", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
    check("rst_data", {rdata, bid, rid, bresp, rresp, buser, ruser}, 0);
    repeat (cyc) @(negedge clk);
    rst_n = 1;
    #1 check("ready_before_edge", {awready, arready}, 0);
    @(negedge clk);
    check("ready_after_release", {awready, arready}, 2'b11);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rm, re, rn, base;
    int w, len;
    logic [1:0] bt;
    logic [3:0] pg;
    mdl_clear();
    reset_dut(3);

    // STATUS after reset
    rd_cmp("status_rst", 32'h7800_0004, 0, 2'd1, 0);
    check("status_rst_zero", rbuf[0], 0);

    // Full 64-beat INCR write/readback of M
    for (int i = 0; i < 64; i++) wbuf[i] = i;
    wr_burst(32'h7800_0100, 63, 2'd1, 4'hF, 0);
    rd_cmp("m_incr", 32'h7800_0100, 63, 2'd1, 0);

    // Partial strobes on a cleared word
    wr1(32'h7800_0104, 0);
    wbuf[0] = 32'hAABB_CCDD;
    wr_burst(32'h7800_0104, 0, 2'd1, 4'b0101, 0);
    rd_burst(32'h7800_0104, 0, 2'd1, 0);
    check("strb_0101", rbuf[0], 32'h00BB_00DD);

    // Clear M, then 5^3 mod 13
    for (int i = 0; i < 64; i++) wbuf[i] = 0;
    wr_burst(32'h7800_0100, 63, 2'd1, 4'hF, 0);
    wr1(32'h7800_0100, 5); wr1(32'h7800_0200, 3); wr1(32'h7800_0300, 13);
    wr1(32'h7800_0000, 1);
    rd_cmp("status_busy", 32'h7800_0004, 0, 2'd1, 0);
    wait_done(ref_modexp(5, 3, 13));
    rd_cmp("res_5_3_13", 32'h7800_0400, 63, 2'd1, 0);
    check("res_word0_is_8", rbuf[0], 8);

    // Randomized exponentiations on word 0
    for (int k = 0; k < 5; k++) begin
      rm = $urandom; re = $urandom_range(1, 255); rn = $urandom | 32'h8000_0001;
      wr1(32'h7800_0100, rm); wr1(32'h7800_0200, re); wr1(32'h7800_0300, rn);
      wr1(32'h7800_0000, 1);
      // An operand write while busy must be dropped
      wr1(32'h7800_0100, ~rm);
      wait_done(ref_modexp(rm, re, rn));
      rd_cmp($sformatf("res_rand%0d", k), 32'h7800_0400, 1, 2'd1, 0);
      rd_cmp($sformatf("m_kept%0d", k), 32'h7800_0100, 0, 2'd1, 0);
    end

    // FIXED burst on STATUS, unmapped read, stalled handshakes
    rd_cmp("status_fixed", 32'h7800_0004, 3, 2'd0, 0);
    rd_cmp("unmapped", 32'h7800_0800, 0, 2'd1, 0);
    rd_cmp("ctrl_reads0", 32'h7800_0000, 0, 2'd1, 0);
    rd_cmp("stall_r", 32'h7800_0200, 1, 2'd1, 5);
    wbuf[0] = 32'h1234_5678;
    wr_burst(32'h7800_0208, 0, 2'd1, 4'hF, 5);
    rd_cmp("stall_w", 32'h7800_0208, 0, 2'd1, 0);

    // Random bursts across RW, RO and unmapped pages
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 5))
        0: pg = 4'h1; 1: pg = 4'h2; 2: pg = 4'h3; 3: pg = 4'h4; 4: pg = 4'h8; default: pg = 4'hC;
      endcase
      len = $urandom_range(0, 7);
      w   = $urandom_range(1, 56);
      bt  = 2'($urandom_range(0, 2));
      for (int i = 0; i <= len; i++) wbuf[i] = $urandom;
      wr_burst(32'h7800_0000 | {20'd0, pg, 8'd0} | 32'(w * 4), len, bt, 4'($urandom_range(1, 15)),
               $urandom_range(0, 2));
      rd_cmp($sformatf("rnd%0d", k), 32'h7800_0000 | {20'd0, pg, 8'd0} | 32'(w * 4), len, 2'd1,
             $urandom_range(0, 2));
    end

    // Reset during a long exponentiation
    wr1(32'h7800_02FC, 32'h8000_0000);
    wr1(32'h7800_03FC, 32'hFFFF_FFFF);
    wr1(32'h7800_0300, 32'hFFFF_FFFF);
    wr1(32'h7800_0000, 1);
    rd_cmp("status_long_busy", 32'h7800_0004, 0, 2'd1, 0);
    reset_dut(2);
    rd_cmp("status_after_rst", 32'h7800_0004, 0, 2'd1, 0);
    rd_cmp("res_after_rst", 32'h7800_0400, 63, 2'd1, 0);
    rd_cmp("n_after_rst", 32'h7800_03F0, 3, 2'd1, 0);
    wr1(32'h7800_0100, 5); wr1(32'h7800_0200, 3); wr1(32'h7800_0300, 13);
    wr1(32'h7800_0000, 1);
    wait_done(ref_modexp(5, 3, 13));
    rd_cmp("res_after_rst_run", 32'h7800_0400, 3, 2'd1, 0);
    base = rbuf[0];
    check("res_after_rst_is_8", base, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
